wb_regfile: RTL and testbench

//   Architectural integer register file; consumer end of the writeback

---
 rtl/wb_regfile.sv | 107 ++++++++++
 tb/tb_wb_regfile.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// Architectural integer register file (x0..x31). It sits at the consumer end
// of the writeback interface: the MEM/WB pipeline register drives the single
// synchronous write port. Two combinational read ports serve the ID stage.
// A same-cycle WB->ID bypass removes the WB/ID read-after-write hazard.
//
// Ports
//   clk       in   1        clock; all state changes on the rising edge
//   rst       in   1        synchronous, active-high reset; clears every entry
//   we_i      in   1        write enable (wb_wreg)
//   waddr_i   in   ADDR_W   write register index (wb_wd)
//   wdata_i   in   DATA_W   write data (wb_wdata)
//   re1_i     in   1        read enable, port 1
//   raddr1_i  in   ADDR_W   read index, port 1
//   rdata1_o  out  DATA_W   read data, port 1 (combinational)
//   re2_i     in   1        read enable, port 2
//   raddr2_i  in   ADDR_W   read index, port 2
//   rdata2_o  out  DATA_W   read data, port 2 (combinational)
//
// Read priority per port: rst -> 0, !re -> 0, x0 -> 0, write bypass -> wdata,
// otherwise the stored value.
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,

    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,

    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o
);

    localparam int unsigned NumPorts = 2;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];

    // A write to x0 is a legal no-op; it must never land in storage.
    logic write_en;
    assign write_en = we_i && (waddr_i != '0);

    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (rst) begin
            // Any write presented during reset is dropped.
            for (int i = 0; i < REG_NUM; i++) begin
                regs_d[i] = '0;
            end
        end else if (write_en) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // -----------------------------------------------------------------------
    // Read ports: identical logic, gathered into arrays so both share one body
    // -----------------------------------------------------------------------
    logic              re_p    [NumPorts];
    logic [ADDR_W-1:0] raddr_p [NumPorts];
    logic [DATA_W-1:0] rdata_p [NumPorts];

    assign re_p[0]    = re1_i;
    assign raddr_p[0] = raddr1_i;
    assign re_p[1]    = re2_i;
    assign raddr_p[1] = raddr2_i;

    for (genvar p = 0; p < NumPorts; p++) begin : g_rd_port
        always_comb begin
            rdata_p[p] = '0;
            if (rst || !re_p[p] || (raddr_p[p] == '0)) begin
                rdata_p[p] = '0;
            end else if (we_i && (waddr_i == raddr_p[p])) begin
                // Bypass: the ID stage sees the value WB is writing this cycle.
                rdata_p[p] = wdata_i;
            end else begin
                rdata_p[p] = regs_q[raddr_p[p]];
            end
        end
    end

    assign rdata1_o = rdata_p[0];
    assign rdata2_o = rdata_p[1];

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//
// Bench for wb_regfile: reset sweep, a table of directed single-cycle vectors
// (write/read, x0, bypass, back-to-back writes, reset priority), then a long
// randomized run against an array reference model.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

    localparam int unsigned REG_NUM = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;

    logic              clk;
    logic              rst;
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              re1_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;

    wb_regfile #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we_i),
        .waddr_i  (waddr_i),
        .wdata_i  (wdata_i),
        .re1_i    (re1_i),
        .raddr1_i (raddr1_i),
        .rdata1_o (rdata1_o),
        .re2_i    (re2_i),
        .raddr2_i (raddr2_i),
        .rdata2_o (rdata2_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total;
    int bad;

    // Reference model: plain array of architectural register values.
    logic [DATA_W-1:0] model [REG_NUM];

    typedef struct {
        logic              rst;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              re1;
        logic [ADDR_W-1:0] raddr1;
        logic              re2;
        logic [ADDR_W-1:0] raddr2;
        logic [DATA_W-1:0] exp1;
        logic [DATA_W-1:0] exp2;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic e1,
                         input logic [ADDR_W-1:0] a1, input logic e2,
                         input logic [ADDR_W-1:0] a2);
        rst      = r;
        we_i     = we;
        waddr_i  = wa;
        wdata_i  = wd;
        re1_i    = e1;
        raddr1_i = a1;
        re2_i    = e2;
        raddr2_i = a2;
    endtask

    // Spec-level read rule for one port, using the model's current contents.
    function automatic logic [DATA_W-1:0] model_read(input logic e,
                                                     input logic [ADDR_W-1:0] a);
        if (rst) return '0;
        if (!e) return '0;
        if (a == 0) return '0;
        if (we_i && waddr_i == a) return wdata_i;
        return model[a];
    endfunction

    // Advance one clock edge and apply the spec's write rule to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) model[i] = '0;
        end else if (we_i && waddr_i != 0) begin
            model[waddr_i] = wdata_i;
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < REG_NUM; i++) model[i] = '0;
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);

        // rst r we wa  wdata          e1 a1  e2 a2  exp1           exp2
        vecs[0]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd6,
                     32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5,
                     32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5,
                     32'h0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0,
                     32'h0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0,
                     32'h0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 1'b1, 5'd8,
                     32'h1, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd7, 1'b1, 5'd8,
                     32'h1, 32'h88};
        vecs[7]  = '{1'b0, 1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 1'b1, 5'd7,
                     32'h2, 32'h2};
        vecs[8]  = '{1'b0, 1'b1, 5'd7, 32'h3, 1'b1, 5'd7, 1'b1, 5'd8,
                     32'h3, 32'h88};
        vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd8,
                     32'h3, 32'h88};
        vecs[10] = '{1'b1, 1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 1'b1, 5'd7,
                     32'h0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd7,
                     32'h0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b1, 5'd31,
                     32'h0, 32'h0};

        // Two-cycle reset pulse; outputs held at 0 while rst is high.
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd9, 32'h1234, 1'b1, 5'd9, 1'b1, 5'd9);
        #1;
        check("rst_hold_rd1", rdata1_o, 32'h0);
        check("rst_hold_rd2", rdata2_o, 32'h0);
        tick();
        tick();

        // Full reset sweep on both ports.
        for (int i = 0; i < REG_NUM; i++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(i), 1'b1, ADDR_W'(REG_NUM - 1 - i));
            #1;
            check("reset_sweep_rd1", rdata1_o, 32'h0);
            check("reset_sweep_rd2", rdata2_o, 32'h0);
            tick();
        end

        // Directed table, one vector per cycle.
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].rst, vecs[v].we, vecs[v].waddr, vecs[v].wdata,
                  vecs[v].re1, vecs[v].raddr1, vecs[v].re2, vecs[v].raddr2);
            #1;
            check($sformatf("vec%0d_rd1", v), rdata1_o, vecs[v].exp1);
            check($sformatf("vec%0d_rd2", v), rdata2_o, vecs[v].exp2);
            tick();
        end

        // Randomized run; reads often aliased onto the write index to hit bypass.
        for (int c = 0; c < 10000; c++) begin
            logic [ADDR_W-1:0] wa;
            logic [ADDR_W-1:0] a1;
            logic [ADDR_W-1:0] a2;
            wa = ADDR_W'($urandom_range(0, REG_NUM - 1));
            a1 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, REG_NUM - 1));
            a2 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, REG_NUM - 1));
            drive(($urandom_range(0, 99) == 0), 1'($urandom), wa, $urandom,
                  ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2);
            #1;
            check("rand_rd1", rdata1_o, model_read(re1_i, raddr1_i));
            check("rand_rd2", rdata2_o, model_read(re2_i, raddr2_i));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
